temporizador_jogo: RTL and testbench
====================================

Name: temporizador_jogo

Overview:
- Timing scheduler for the memory-game datapath.
- Shares one counter between the three timed phases requested by the game control unit: LED-on display, LED-off gap, and the player-response window.
- Returns one-cycle completion pulses fimLedsOn, fimLedsOff and timeout to the control unit.
- Sits between the control unit's state-flag outputs and its timing inputs.

Parameters:
- T_LED_ON, 1000, LED-on duration in clock cycles (1 s at 1 kHz).
- T_LED_OFF, 500, LED-off duration in clock cycles.
- T_TIMEOUT, 5000, response window in clock cycles.
- W, 13, counter width; must satisfy 2^W >= max(T_*).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- estado_ledsOn  in  1  request: time LED-on phase (level).
- estado_ledsOff  in  1  request: time LED-off phase (level).
- estado_espera  in  1  request: time response window (level).
- fimLedsOn  out  1  one-cycle pulse: LED-on phase elapsed.
- fimLedsOff  out  1  one-cycle pulse: LED-off phase elapsed.
- timeout  out  1  one-cycle pulse: response window elapsed.
- conflito  out  1  sticky: more than one request was high in the same cycle.
- db_contagem  out  W  current counter value (debug).
- db_estado  out  2  FSM state code (debug).

Behaviour:
- Reset (reset=0, async): all outputs 0; counter 0; state OCIOSO; tipo = NENHUM.
- Requests are levels. Priority when several are high: ledsOn > ledsOff > espera. Any cycle with two or more requests high sets conflito; only reset clears it.
- Register tipo (2 bits: NENHUM/ON/OFF/ESP) holds the phase being timed. LIMIT = the T_* parameter selected by tipo.
- State OCIOSO (00): on the highest-priority active request, load tipo, clear counter, go to CONTA. No request: stay.
- State CONTA (01):
  - Counter increments by 1 each cycle.
  - If the request for tipo drops: abort, no pulse. If another request is high, restart directly into CONTA with the new tipo and counter 0; otherwise go to OCIOSO.
  - When counter == LIMIT-1 and the request is still high: go to FIM.
- State FIM (10):
  - Exactly one of fimLedsOn/fimLedsOff/timeout is high, selected by tipo.
  - Next state is AGUARDA, unless a request of a different tipo is already high; then go straight to CONTA with the new tipo and counter 0.
- State AGUARDA (11):
  - The same-tipo request still high: stay; no re-trigger, no second pulse.
  - A different-tipo request high: CONTA with the new tipo and counter 0.
  - No request: OCIOSO.
- Latency: request first high in cycle n (from OCIOSO) → pulse in cycle n+LIMIT+1, width exactly 1 cycle.
- The control unit reacts to the pulse on the next edge. The next phase's request is therefore seen in AGUARDA or FIM with zero idle cycles lost.
- Counter never wraps: the terminal compare precedes overflow, and the parameter constraint guarantees range.
- Pulses are Moore outputs decoded from the FIM state and tipo (glitch-free at the edge; not combinational from inputs).
- Reset asserted mid-count: immediate return to reset values. After release, an active request starts a fresh count from 0.

Optional Feature:
- Macro TEMPORIZADOR_DIFICIL_EN.
- Defined: adds input port dificil (1 bit). While dificil=1 at phase start, LIMIT is the selected T_* shifted right by 1 (halved, floor, minimum 1). The value is latched with tipo, so changing dificil mid-count has no effect.
- Undefined: port absent; full T_* limits always.

Decomposition:
- Package temporizador_pkg holds:
  - state codes OCIOSO/CONTA/FIM/AGUARDA;
  - tipo codes NENHUM/ON/OFF/ESP;
  - default limit constants.
- One natural sub-module: contador_limite. It is a W-bit up-counter with synchronous clear, enable and terminal-count output against a LIMIT input. The FSM and priority/limit muxing stay in the top.

Test Plan:
- T_LED_ON=4: estado_ledsOn high from cycle 10 → fimLedsOn high only in cycle 15; db_contagem reaches 3.
- Chained phases: ledsOn (4), then the control unit drops ledsOn and raises ledsOff the cycle after the pulse (T_LED_OFF=2) → fimLedsOff exactly 3 cycles after ledsOff rises; no idle gap.
- Abort: estado_espera high for 3 cycles with T_TIMEOUT=8, then low → no timeout pulse; state returns to OCIOSO.
- Conflict: ledsOn and espera high together at cycle 5 → conflito=1 from cycle 6 and stays 1; the LED-on phase is timed; no timeout pulse while espera is shadowed.
- Reset mid-count: reset=0 at counter=2 → outputs and counter 0 immediately. After release with ledsOn held, the pulse arrives LIMIT+1 cycles after release.
- With TEMPORIZADOR_DIFICIL_EN and dificil=1, T_TIMEOUT=8: espera held → timeout 5 cycles after request.

Source files
------------

// File: rtl/temporizador_pkg.sv
// Shared codes and default limits for the memory-game timing scheduler.
package temporizador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CONTA   = 2'b01,
        FIM     = 2'b10,
        AGUARDA = 2'b11
    } estado_t;

    typedef enum logic [1:0] {
        NENHUM = 2'b00,
        ON     = 2'b01,
        OFF    = 2'b10,
        ESP    = 2'b11
    } tipo_t;

    localparam int unsigned T_LED_ON_DEF  = 1000;
    localparam int unsigned T_LED_OFF_DEF = 500;
    localparam int unsigned T_TIMEOUT_DEF = 5000;
    localparam int unsigned W_DEF         = 13;

    // Fixed priority: ledsOn > ledsOff > espera.
    function automatic tipo_t prioridade(input logic on, input logic off, input logic esp);
        tipo_t t;
        t = NENHUM;
        if (esp) t = ESP;
        if (off) t = OFF;
        if (on)  t = ON;
        return t;
    endfunction

endpackage

// File: rtl/temporizador_jogo_contador_limite.sv
// W-bit up-counter with synchronous clear, enable and terminal flag at limite-1.
module contador_limite #(
    parameter int unsigned W = 13
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limite,
    output logic [W-1:0] contagem,
    output logic         terminal
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable) begin
            contagem <= contagem + W'(1);
        end
    end

    assign terminal = (contagem == (limite - W'(1)));

endmodule

// File: rtl/temporizador_jogo.sv
// Shared-counter timer for LED-on, LED-off and response-window phases.
// Optional macro TEMPORIZADOR_DIFICIL_EN adds input dificil (halves the limit latched at phase start).
module temporizador_jogo
    import temporizador_pkg::*;
#(
    parameter int unsigned T_LED_ON  = T_LED_ON_DEF,
    parameter int unsigned T_LED_OFF = T_LED_OFF_DEF,
    parameter int unsigned T_TIMEOUT = T_TIMEOUT_DEF,
    parameter int unsigned W         = W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         estado_ledsOn,
    input  logic         estado_ledsOff,
    input  logic         estado_espera,
`ifdef TEMPORIZADOR_DIFICIL_EN
    input  logic         dificil,
`endif
    output logic         fimLedsOn,
    output logic         fimLedsOff,
    output logic         timeout,
    output logic         conflito,
    output logic [W-1:0] db_contagem,
    output logic [1:0]   db_estado
);

    estado_t        estado, estado_prox;
    tipo_t          tipo, tipo_prox;
    tipo_t          sel, sel_outro;
    logic           carrega, ativo, terminal, modo_dificil;
    logic [W-1:0]   limite, limite_base, limite_prox;

`ifdef TEMPORIZADOR_DIFICIL_EN
    assign modo_dificil = dificil;
`else
    assign modo_dificil = 1'b0;
`endif

    assign sel       = prioridade(estado_ledsOn, estado_ledsOff, estado_espera);
    // Highest-priority request whose phase differs from the one being timed.
    assign sel_outro = prioridade(estado_ledsOn  && (tipo != ON),
                                  estado_ledsOff && (tipo != OFF),
                                  estado_espera  && (tipo != ESP));

    always_comb begin
        ativo = 1'b0;
        case (tipo)
            ON:      ativo = estado_ledsOn;
            OFF:     ativo = estado_ledsOff;
            ESP:     ativo = estado_espera;
            default: ativo = 1'b0;
        endcase
    end

    always_comb begin
        estado_prox = estado;
        tipo_prox   = tipo;
        carrega     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (sel != NENHUM) begin
                    carrega = 1'b1; tipo_prox = sel; estado_prox = CONTA;
                end
            end
            CONTA: begin
                if (!ativo) begin
                    if (sel_outro != NENHUM) begin
                        carrega = 1'b1; tipo_prox = sel_outro; estado_prox = CONTA;
                    end else begin
                        tipo_prox = NENHUM; estado_prox = OCIOSO;
                    end
                end else if (terminal) begin
                    estado_prox = FIM;
                end
            end
            FIM: begin
                if (sel_outro != NENHUM) begin
                    carrega = 1'b1; tipo_prox = sel_outro; estado_prox = CONTA;
                end else begin
                    estado_prox = AGUARDA;
                end
            end
            AGUARDA: begin
                if (!ativo) begin
                    if (sel_outro != NENHUM) begin
                        carrega = 1'b1; tipo_prox = sel_outro; estado_prox = CONTA;
                    end else begin
                        tipo_prox = NENHUM; estado_prox = OCIOSO;
                    end
                end
            end
            default: begin
                tipo_prox = NENHUM; estado_prox = OCIOSO;
            end
        endcase
    end

    // Limit is latched together with tipo, so dificil is sampled only at phase start.
    always_comb begin
        limite_base = '0;
        case (tipo_prox)
            ON:      limite_base = W'(T_LED_ON);
            OFF:     limite_base = W'(T_LED_OFF);
            ESP:     limite_base = W'(T_TIMEOUT);
            default: limite_base = '0;
        endcase
        limite_prox = limite_base;
        if (modo_dificil) begin
            limite_prox = limite_base >> 1;
            if (limite_prox == '0) limite_prox = W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            tipo     <= NENHUM;
            limite   <= '0;
            conflito <= 1'b0;
        end else begin
            estado <= estado_prox;
            tipo   <= tipo_prox;
            if (carrega) limite <= limite_prox;
            if ((estado_ledsOn && estado_ledsOff) || (estado_ledsOn && estado_espera) ||
                (estado_ledsOff && estado_espera))
                conflito <= 1'b1;
        end
    end

    contador_limite #(.W(W)) u_contador (
        .clock    (clock),
        .reset    (reset),
        .clear    (carrega),
        .enable   ((estado == CONTA) && ativo && !terminal),
        .limite   (limite),
        .contagem (db_contagem),
        .terminal (terminal)
    );

    assign fimLedsOn  = (estado == FIM) && (tipo == ON);
    assign fimLedsOff = (estado == FIM) && (tipo == OFF);
    assign timeout    = (estado == FIM) && (tipo == ESP);
    assign db_estado  = estado;

endmodule

// File: tb/tb_temporizador_jogo.sv
// Self-checking bench for temporizador_jogo: vector table, directed corner cases, randomized run vs model.
module tb_temporizador_jogo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        estado_ledsOn = 1'b0, estado_ledsOff = 1'b0, estado_espera = 1'b0;
`ifdef TEMPORIZADOR_DIFICIL_EN
    logic        dificil = 1'b0;
`endif
    logic        fimLedsOn, fimLedsOff, timeout, conflito;
    logic [12:0] db_contagem;
    logic [1:0]  db_estado;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    temporizador_jogo #(
        .T_LED_ON  (4),
        .T_LED_OFF (2),
        .T_TIMEOUT (8),
        .W         (13)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .estado_ledsOn  (estado_ledsOn),
        .estado_ledsOff (estado_ledsOff),
        .estado_espera  (estado_espera),
`ifdef TEMPORIZADOR_DIFICIL_EN
        .dificil        (dificil),
`endif
        .fimLedsOn      (fimLedsOn),
        .fimLedsOff     (fimLedsOff),
        .timeout        (timeout),
        .conflito       (conflito),
        .db_contagem    (db_contagem),
        .db_estado      (db_estado)
    );

    task automatic chk(input string nome, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic on, input logic off, input logic esp);
        estado_ledsOn  = on;
        estado_ledsOff = off;
        estado_espera  = esp;
    endtask

    // Behavioural reference: phase type, cycles timed so far, pulse/wait flags.
    int m_tipo, m_cnt;
    bit m_pulse, m_wait, m_conf;

    function automatic int lim(input int t);
        case (t)
            1: return 4;
            2: return 2;
            3: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int best(input logic [3:1] r, input int excl);
        for (int t = 1; t <= 3; t++)
            if (r[t] && t != excl) return t;
        return 0;
    endfunction

    task automatic model_reset();
        m_tipo = 0; m_cnt = 0; m_pulse = 0; m_wait = 0; m_conf = 0;
    endtask

    task automatic model_start_or_idle(input int nt);
        if (nt != 0) begin
            m_tipo = nt; m_cnt = 0; m_wait = 0;
        end else begin
            m_tipo = 0; m_wait = 0;
        end
    endtask

    task automatic model_step(input logic [3:1] r);
        if ($countones(r) >= 2) m_conf = 1;
        if (m_pulse) begin
            m_pulse = 0;
            if (best(r, m_tipo) != 0) model_start_or_idle(best(r, m_tipo));
            else m_wait = 1;
        end else if (m_tipo == 0) begin
            model_start_or_idle(best(r, 0));
        end else if (!r[m_tipo]) begin
            model_start_or_idle(best(r, m_tipo));
        end else if (!m_wait) begin
            m_cnt++;
            if (m_cnt == lim(m_tipo)) m_pulse = 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_req(0, 0, 0);
        step();
        step();
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       on, off, esp;
        logic [1:0] st;
        logic       p_on, p_off, p_to;
        int         cnt;
    } vec_t;

    vec_t tbl[30];

    initial begin
        int got, width;
        logic [3:1] r;

        // Inputs held for one edge; expected outputs after that edge (cnt -1 = not checked).
        tbl[0]  = '{1,0,0, 2'd1, 0,0,0,  0};
        tbl[1]  = '{1,0,0, 2'd1, 0,0,0,  1};
        tbl[2]  = '{1,0,0, 2'd1, 0,0,0,  2};
        tbl[3]  = '{1,0,0, 2'd1, 0,0,0,  3};
        tbl[4]  = '{1,0,0, 2'd2, 1,0,0, -1};
        tbl[5]  = '{1,0,0, 2'd3, 0,0,0, -1};
        tbl[6]  = '{0,1,0, 2'd1, 0,0,0,  0};
        tbl[7]  = '{0,1,0, 2'd1, 0,0,0,  1};
        tbl[8]  = '{0,1,0, 2'd2, 0,1,0, -1};
        tbl[9]  = '{0,0,0, 2'd3, 0,0,0, -1};
        tbl[10] = '{0,0,0, 2'd0, 0,0,0, -1};
        tbl[11] = '{0,0,1, 2'd1, 0,0,0,  0};
        tbl[12] = '{0,0,1, 2'd1, 0,0,0,  1};
        tbl[13] = '{0,0,1, 2'd1, 0,0,0,  2};
        tbl[14] = '{0,0,0, 2'd0, 0,0,0, -1};
        tbl[15] = '{0,0,0, 2'd0, 0,0,0, -1};
        tbl[16] = '{1,0,0, 2'd1, 0,0,0,  0};
        tbl[17] = '{1,0,0, 2'd1, 0,0,0,  1};
        tbl[18] = '{1,0,0, 2'd1, 0,0,0,  2};
        tbl[19] = '{1,0,0, 2'd1, 0,0,0,  3};
        tbl[20] = '{1,0,0, 2'd2, 1,0,0, -1};
        tbl[21] = '{0,0,1, 2'd1, 0,0,0,  0};
        tbl[22] = '{0,0,0, 2'd0, 0,0,0, -1};
        tbl[23] = '{0,1,0, 2'd1, 0,0,0,  0};
        tbl[24] = '{0,1,0, 2'd1, 0,0,0,  1};
        tbl[25] = '{0,1,0, 2'd2, 0,1,0, -1};
        tbl[26] = '{0,1,0, 2'd3, 0,0,0, -1};
        tbl[27] = '{0,1,0, 2'd3, 0,0,0, -1};
        tbl[28] = '{0,1,0, 2'd3, 0,0,0, -1};
        tbl[29] = '{0,0,0, 2'd0, 0,0,0, -1};

        // Reset state
        step();
        chk("reset_outputs", {fimLedsOn, fimLedsOff, timeout, conflito}, 0);
        chk("reset_estado", db_estado, 0);
        chk("reset_contagem", db_contagem, 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 30; i++) begin
            set_req(tbl[i].on, tbl[i].off, tbl[i].esp);
            step();
            chk($sformatf("vec%0d_estado", i), db_estado, tbl[i].st);
            chk($sformatf("vec%0d_pulses", i), {fimLedsOn, fimLedsOff, timeout},
                {tbl[i].p_on, tbl[i].p_off, tbl[i].p_to});
            chk($sformatf("vec%0d_conflito", i), conflito, 0);
            if (tbl[i].cnt >= 0) chk($sformatf("vec%0d_contagem", i), db_contagem, tbl[i].cnt);
        end

        // Conflict: ledsOn and espera together; LED-on phase wins, espera never times out.
        do_reset();
        repeat (5) step();
        chk("conf_before", conflito, 0);
        set_req(1, 0, 1);
        step();
        chk("conf_set", conflito, 1);
        chk("conf_estado", db_estado, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("conf_no_timeout", timeout, 0);
            chk("conf_fimLedsOn", fimLedsOn, (i == 4) ? 1 : 0);
        end
        set_req(0, 0, 0);
        repeat (6) begin
            step();
            chk("conf_after_timeout", timeout, 0);
            chk("conf_sticky", conflito, 1);
        end

        // Reset asserted mid-count, then released with ledsOn held.
        do_reset();
        set_req(1, 0, 0);
        repeat (3) step();
        chk("midrst_pre_cnt", db_contagem, 2);
        #2 reset = 1'b0;
        #1;
        chk("midrst_cnt", db_contagem, 0);
        chk("midrst_estado", db_estado, 0);
        chk("midrst_outputs", {fimLedsOn, fimLedsOff, timeout, conflito}, 0);
        step();
        reset = 1'b1;
        got = 0; width = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (fimLedsOn) begin
                width++;
                if (got == 0) got = k;
            end
        end
        chk("midrst_latency", got, 5);
        chk("midrst_width", width, 1);

`ifdef TEMPORIZADOR_DIFICIL_EN
        // Hard mode: limit latched at start, mid-count change of dificil ignored.
        do_reset();
        dificil = 1'b1;
        set_req(0, 0, 1);
        got = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 2) dificil = 1'b0;
            if (timeout && got == 0) got = k;
        end
        chk("dificil_latency", got, 5);
        dificil = 1'b0;
`endif

        // Randomized: one-hot segments, then arbitrary mixes, against the model.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int n = 0; n < 60; n++) begin
                int dur;
                dur = $urandom_range(1, 12);
                if (pass == 0) begin
                    int p;
                    p = $urandom_range(0, 3);
                    r = '0;
                    if (p != 0) r[p] = 1'b1;
                end else begin
                    r = 3'($urandom_range(0, 7));
                end
                for (int c = 0; c < dur; c++) begin
                    set_req(r[1], r[2], r[3]);
                    model_step(r);
                    step();
                    chk("rand_outputs", {fimLedsOn, fimLedsOff, timeout, conflito},
                        {m_pulse && m_tipo == 1, m_pulse && m_tipo == 2,
                         m_pulse && m_tipo == 3, m_conf});
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
